// File: rtl/gray_conv_ctrl_if.sv
// Handshake and counter-control bundle for the gray-code conversion sequencer.
// master is the sequencer's view; slave is the front end / counter / consumer view.
interface gray_conv_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] gray_in;
    logic             cnt_clr;
    logic             cnt_en;
    logic             busy;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overflow;

    modport master (
        input  start,
        input  stop,
        input  gray_in,
        input  dout_ready,
        output cnt_clr,
        output cnt_en,
        output busy,
        output dout,
        output dout_valid,
        output overflow
    );

    modport slave (
        output start,
        output stop,
        output gray_in,
        output dout_ready,
        input  cnt_clr,
        input  cnt_en,
        input  busy,
        input  dout,
        input  dout_valid,
        input  overflow
    );
endinterface

// File: rtl/gray_conv_ctrl.sv
// Conversion sequencer for an external gray counter: clear, run until stop or
// terminal count, freeze, convert the frozen gray value and hand it out.
module gray_conv_ctrl #(
    parameter int WIDTH = 8  // minimum 2
) (
    input  logic              clk,
    input  logic              reset,
    gray_conv_ctrl_if.master  io_bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] TERM_GRAY = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_cnt_clr;
    logic             r_cnt_en;
    logic             r_busy;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;

    logic             w_cnt_clr_nxt;
    logic             w_cnt_en_nxt;
    logic             w_busy_nxt;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_dout_valid_nxt;
    logic             w_overflow_nxt;
    logic             w_terminal;
    logic [WIDTH-1:0] w_bin;

    assign w_terminal = (io_bus.gray_in == TERM_GRAY);
    assign w_bin      = gray2bin(io_bus.gray_in);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next output values; outputs are decoded from the next
    // state so that every output is registered and lines up with its state.
    always_comb begin
        w_state_nxt    = r_state;
        w_overflow_nxt = r_overflow;
        w_dout_nxt     = r_dout;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.start) begin
                    w_state_nxt    = ST_CLEAR;
                    w_overflow_nxt = 1'b0;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // stop has priority over a simultaneous terminal count
                if (io_bus.stop) begin
                    w_state_nxt    = ST_CAPTURE;
                    w_overflow_nxt = 1'b0;
                end else if (w_terminal) begin
                    w_state_nxt    = ST_CAPTURE;
                    w_overflow_nxt = 1'b1;
                end else begin
                    w_state_nxt    = ST_RUN;
                end
            end
            ST_CAPTURE: begin
                w_dout_nxt  = w_bin;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (io_bus.dout_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_overflow_nxt = 1'b0;
            end
        endcase

        w_cnt_clr_nxt    = (w_state_nxt == ST_CLEAR);
        w_cnt_en_nxt     = (w_state_nxt == ST_RUN);
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        w_dout_valid_nxt = (w_state_nxt == ST_HOLD);
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_clr    <= 1'b0;
            r_cnt_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_dout       <= {WIDTH{1'b0}};
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_cnt_clr    <= w_cnt_clr_nxt;
            r_cnt_en     <= w_cnt_en_nxt;
            r_busy       <= w_busy_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_overflow   <= w_overflow_nxt;
        end
    end

    assign io_bus.cnt_clr    = r_cnt_clr;
    assign io_bus.cnt_en     = r_cnt_en;
    assign io_bus.busy       = r_busy;
    assign io_bus.dout       = r_dout;
    assign io_bus.dout_valid = r_dout_valid;
    assign io_bus.overflow   = r_overflow;

endmodule

// File: tb/tb_gray_conv_ctrl.sv
// Directed bench for gray_conv_ctrl with a saturating gray counter model in the loop.
module tb_gray_conv_ctrl;

    logic       clk;
    logic       reset;
    logic       use_model;
    logic [7:0] dir_gray;
    logic [7:0] m_cnt;
    logic [7:0] m_gray;
    int         n_vec;
    int         n_err;

    gray_conv_ctrl_if #(.WIDTH(8)) bus ();

    gray_conv_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External counter model: clear, count while enabled, saturate at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 8'd0;
        end else if (bus.cnt_clr) begin
            m_cnt <= 8'd0;
        end else if (bus.cnt_en && (m_cnt != 8'hFF)) begin
            m_cnt <= m_cnt + 8'd1;
        end
    end

    assign m_gray      = m_cnt ^ (m_cnt >> 1);
    assign bus.gray_in = use_model ? m_gray : dir_gray;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic clr, input logic en,
                             input logic bsy, input logic vld);
        check_val({tag, ".cnt_clr"},    32'(bus.cnt_clr),    32'(clr));
        check_val({tag, ".cnt_en"},     32'(bus.cnt_en),     32'(en));
        check_val({tag, ".busy"},       32'(bus.busy),       32'(bsy));
        check_val({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(vld));
    endtask

    task automatic check_res(input string tag, input logic [7:0] d, input logic ovf);
        check_val({tag, ".dout"},     32'(bus.dout),     32'(d));
        check_val({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed conversion: start, stop on first RUN edge, land in HOLD.
    task automatic run_conv(input logic [7:0] g);
        dir_gray  = g;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.stop  = 1'b1;
        tick();
        bus.stop  = 1'b0;
        tick();
    endtask

    task automatic handshake(input string tag);
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        check_ctl({tag, ".ack"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev;
        int         bad_steps;
        n_vec          = 0;
        n_err          = 0;
        reset          = 1'b1;
        use_model      = 1'b0;
        dir_gray       = 8'h00;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_res("rst", 8'h00, 1'b0);
        reset = 1'b0;
        tick();
        check_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic conversion with step-by-step timing
        dir_gray  = 8'h0D;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_ctl("t1.clear", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_ctl("t1.run", 1'b0, 1'b1, 1'b1, 1'b0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_ctl("t1.capture", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_ctl("t1.hold", 1'b0, 1'b0, 1'b1, 1'b1);
        check_res("t1.hold", 8'h09, 1'b0);
        handshake("t1");
        check_val("t1.dout_kept", 32'(bus.dout), 32'h09);

        // Counter in loop: 37 RUN cycles
        use_model = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        prev      = bus.gray_in;
        bad_steps = 0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if ($countones(prev ^ bus.gray_in) != 1) bad_steps++;
            prev = bus.gray_in;
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
        tick();
        check_val("t2.gray_1bit_steps", 32'(bad_steps), 32'd0);
        check_ctl("t2.hold", 1'b0, 1'b0, 1'b1, 1'b1);
        check_res("t2.hold", 8'd37, 1'b0);
        handshake("t2");

        // Overflow: never stop, counter saturates at terminal gray 8'h80
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.dout_valid) break;
            tick();
        end
        check_val("t3.valid_seen", 32'(bus.dout_valid), 32'd1);
        check_res("t3.ovf", 8'hFF, 1'b1);
        handshake("t3");
        check_val("t3.ovf_kept_idle", 32'(bus.overflow), 32'd1);

        // Back-to-back start clears overflow; stop/terminal collision
        use_model = 1'b0;
        dir_gray  = 8'h80;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_ctl("t4.clear", 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("t4.ovf_cleared", 32'(bus.overflow), 32'd0);
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
        check_ctl("t4.hold", 1'b0, 1'b0, 1'b1, 1'b1);
        check_res("t4.collide", 8'hFF, 1'b0);
        handshake("t4");

        // Backpressure: start/stop/gray wiggle while held in HOLD
        run_conv(8'h2A);
        check_res("t5.hold", 8'h33, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.start = (i % 2 == 0);
            bus.stop  = (i % 2 != 0);
            dir_gray  = 8'(i * 37);
            tick();
            check_ctl("t5.bp", 1'b0, 1'b0, 1'b1, 1'b1);
            check_res("t5.bp", 8'h33, 1'b0);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        handshake("t5");
        tick();
        check_ctl("t5.not_queued", 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN
        dir_gray  = 8'h00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check_ctl("t6.run", 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_ctl("t6.async", 1'b0, 1'b0, 1'b0, 1'b0);
        check_res("t6.async", 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_ctl("t6.stop_ignored", 1'b0, 1'b0, 1'b0, 1'b0);
        run_conv(8'hFF);
        check_ctl("t6.hold", 1'b0, 1'b0, 1'b1, 1'b1);
        check_res("t6.after", 8'hAA, 1'b0);
        handshake("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gray_conv_ctrl.md
Name: gray_conv_ctrl

Overview:
- Conversion sequencer for the 8-bit gray-code counter.
- Runs one conversion per request: clears the external counter, enables it until a stop event or terminal count, then freezes it.
- Captures the frozen gray value, converts it to binary and hands it out through a valid/ready interface.
- Sits between the measurement front end (start/stop events) and the counter, time-to-digital/ramp style.

Parameters:
WIDTH, 8, counter and result width in bits (minimum 2)

Ports:
clk         input   1      system clock, all logic on rising edge
reset       input   1      asynchronous, active-high reset
start       input   1      conversion request, sampled in IDLE only
stop        input   1      stop event, synchronous to clk, sampled in RUN only
gray_in     input   WIDTH  gray-coded count from the external gray counter
cnt_clr     output  1      synchronous clear to counter, one-cycle pulse
cnt_en      output  1      count enable to counter
busy        output  1      high in every state except IDLE
dout        output  WIDTH  binary result, stable while dout_valid=1
dout_valid  output  1      result available
dout_ready  input   1      consumer accepts result
overflow    output  1      terminal count reached without stop; valid with dout_valid

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all outputs registered and 0 during/after reset (cnt_clr, cnt_en, busy, dout, dout_valid, overflow); state = IDLE. Reset asserted mid-conversion aborts immediately, with no result.
- FSM states: IDLE, CLEAR, RUN, CAPTURE, HOLD.
- IDLE:
  - busy=0.
  - start=1 -> CLEAR, and overflow cleared.
  - stop ignored.
- CLEAR:
  - cnt_clr=1, cnt_en=0, busy=1, for exactly one cycle.
  - Always -> RUN.
- RUN:
  - cnt_en=1, cnt_clr=0.
  - Each cycle, evaluate stop and gray_in:
    - stop=1 -> CAPTURE, overflow stays 0.
    - stop=0 and gray_in == terminal gray (MSB=1, rest 0; binary all-ones) -> CAPTURE, overflow set to 1.
    - stop=1 and terminal in the same cycle: stop wins, overflow=0.
    - otherwise stay in RUN.
  - cnt_en deasserts on the cycle entering CAPTURE; the counter is frozen from then on.
- CAPTURE (1 cycle):
  - dout <= gray2bin(gray_in), dout_valid <= 1.
  - -> HOLD.
  - Gray-to-binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0. Purely combinational on the frozen gray_in, registered into dout.
- HOLD:
  - dout_valid=1; dout and overflow held constant.
  - dout_ready=1 -> IDLE next cycle; dout_valid=0 and busy=0 from then on. dout keeps its last value.
  - dout_ready=0 -> stay in HOLD, no timeout.
- start while busy (CLEAR/RUN/CAPTURE/HOLD): ignored, not queued.
- stop outside RUN: ignored.
- dout_ready outside HOLD: ignored.
- Latency:
  - start sampled -> cnt_clr next cycle.
  - stop sampled -> dout_valid 2 cycles later (CAPTURE, then HOLD visible).
  - Minimum conversion, start to dout_valid: 4 cycles.
- Back-to-back: start may be asserted in the cycle after the handshake completes (IDLE); the next conversion follows at full rate.

Test Plan:
1. Basic conversion: pulse start; verify cnt_clr=1 for one cycle, then cnt_en=1. Drive gray_in=8'h0D, stop=1 for one cycle -> cnt_en=0 next cycle, dout=8'h09, dout_valid=1, overflow=0 two cycles after stop.
2. Counter in loop: connect the gray counter model; start, then stop after 37 RUN cycles -> dout equals the binary of the frozen count (37 ±0 relative to the model's enable latency). Check that every captured gray_in differs from the previous one in 1 bit.
3. Overflow: start, never stop; gray_in reaches 8'h80 -> dout=8'hFF, overflow=1. The next start clears overflow to 0.
4. Stop/terminal collision: gray_in=8'h80 and stop=1 in the same cycle -> dout=8'hFF, overflow=0.
5. Backpressure: hold dout_ready=0 for 10 cycles while pulsing start and stop -> dout, dout_valid and overflow unchanged, busy=1, no cnt_clr. Raising dout_ready -> dout_valid=0 and busy=0 next cycle.
6. Reset mid-RUN: assert reset asynchronously between clock edges during RUN -> all outputs 0 immediately. After release, stop has no effect and a new start gives a correct conversion.
